// File: rtl/jtkcpu_pkg.sv
// Shared KCPU definitions: multi-shift op encodings, condition-code bit
// positions (common with the ALU) and small helpers used by the shifter.
package jtkcpu_pkg;

  // Multi-shift operation encodings; 5..7 are reserved.
  localparam logic [2:0] MSH_LSR = 3'd0;
  localparam logic [2:0] MSH_ASR = 3'd1;
  localparam logic [2:0] MSH_ASL = 3'd2;
  localparam logic [2:0] MSH_ROR = 3'd3;
  localparam logic [2:0] MSH_ROL = 3'd4;

  // 6809-style condition-code bit indices.
  localparam int CC_C = 0;
  localparam int CC_V = 1;
  localparam int CC_Z = 2;
  localparam int CC_N = 3;

  // Shifter control states.
  typedef enum logic {
    MSH_IDLE = 1'b0,
    MSH_BUSY = 1'b1
  } msh_state_e;

  // True for the five defined shift/rotate operations.
  function automatic logic msh_op_valid(input logic [2:0] op);
    return op <= MSH_ROL;
  endfunction

  // Packs the four arithmetic flags at their condition-code positions.
  function automatic logic [3:0] cc_pack(input logic n, input logic z,
                                         input logic v, input logic c);
    logic [3:0] f;
    f       = '0;
    f[CC_N] = n;
    f[CC_Z] = z;
    f[CC_V] = v;
    f[CC_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/jtkcpu_mshift_step.sv
// One single-bit shift/rotate step. Rotations go through the carry, so
// data plus carry form a (W+1)-bit ring. vflag reports an MSB change for
// the ops whose overflow is defined that way (ASL, ROL).
module jtkcpu_mshift_step
  import jtkcpu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] din,
  input  logic         cin,
  output logic [W-1:0] dout,
  output logic         cout,
  output logic         vflag
);

  // Select the shifted value and the bit that falls out.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    dout  = din;
    cout  = cin;
    vflag = 1'b0;
    case (op)
      MSH_LSR: begin
        dout = {1'b0, din[W-1:1]};
        cout = din[0];
      end
      MSH_ASR: begin
        dout = {din[W-1], din[W-1:1]};
        cout = din[0];
      end
      MSH_ASL: begin
        dout = {din[W-2:0], 1'b0};
        cout = din[W-1];
      end
      MSH_ROR: begin
        dout = {cin, din[W-1:1]};
        cout = din[0];
      end
      MSH_ROL: begin
        dout = {din[W-2:0], cin};
        cout = din[W-1];
      end
      default: begin
        dout = din;
        cout = cin;
      end
    endcase
    if (op == MSH_ASL || op == MSH_ROL) vflag = din[W-1] ^ dout[W-1];
  end

endmodule

// File: rtl/jtkcpu_mshift.sv
// Iterative multi-bit shifter/rotator. A start latches the operand and
// count; each enabled cycle applies up to STEP single-bit steps through a
// chain of step stages, and the result plus N/Z/V/C is registered together
// with a one-cen-period done pulse when the count runs out.
module jtkcpu_mshift
  import jtkcpu_pkg::*;
#(
  parameter int W    = 16,
  parameter int CW   = 5,
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          start,
  input  logic          abort,
  input  logic [2:0]    op,
  input  logic [W-1:0]  din,
  input  logic [CW-1:0] cnt,
  input  logic          cin,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  dout,
  output logic          c_out,
  output logic          v_out,
  output logic          n_out,
  output logic          z_out
);

  msh_state_e    r_state, w_state_nxt;
  logic [2:0]    r_op;
  logic [W-1:0]  r_data;
  logic          r_carry;
  logic          r_vacc;
  logic [CW-1:0] r_rem;
  logic          r_done;
  logic [W-1:0]  r_dout;
  logic [3:0]    r_cc;

  // Step chain: element 0 is the working register, element STEP the
  // value after this cycle's enabled stages.
  logic [W-1:0]    w_sd [0:STEP];
  logic            w_sc [0:STEP];
  logic [STEP-1:0] w_sv;
  logic            w_vstep;
  logic [31:0]     w_rem32;
  logic [31:0]     w_rem_nxt32;
  logic            w_load;
  logic            w_imm;
  logic            w_fin;

  assign w_sd[0] = r_data;
  assign w_sc[0] = r_carry;
  assign w_rem32 = 32'(r_rem);

  // Stage i runs only while more than i single-bit steps remain, so the
  // last cycle applies exactly min(STEP, rem) steps.
  for (genvar i = 0; i < STEP; i++) begin : g_stage
    logic [W-1:0] w_nd;
    logic         w_nc;
    logic         w_nv;
    logic         w_en;

    assign w_en = (w_rem32 > 32'(i));

    jtkcpu_mshift_step #(.W(W)) u_step (
      .op    (r_op),
      .din   (w_sd[i]),
      .cin   (w_sc[i]),
      .dout  (w_nd),
      .cout  (w_nc),
      .vflag (w_nv)
    );

    assign w_sd[i+1] = w_en ? w_nd : w_sd[i];
    assign w_sc[i+1] = w_en ? w_nc : w_sc[i];
    assign w_sv[i]   = w_en & w_nv;
  end

  assign w_vstep     = |w_sv;
  assign w_rem_nxt32 = (w_rem32 > 32'(STEP)) ? (w_rem32 - 32'(STEP)) : '0;

  // Next-state and control decode: load a real operation, complete a
  // zero-length one immediately, or finish when the count runs out.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_imm       = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      MSH_IDLE: begin
        if (start) begin
          if (cnt == '0 || !msh_op_valid(op)) begin
            w_imm = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = MSH_BUSY;
          end
        end
      end
      MSH_BUSY: begin
        if (abort) begin
          w_state_nxt = MSH_IDLE;
        end else if (w_rem_nxt32 == '0) begin
          w_fin       = 1'b1;
          w_state_nxt = MSH_IDLE;
        end
      end
      default: w_state_nxt = MSH_IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n)   r_state <= MSH_IDLE;
    else if (cen) r_state <= w_state_nxt;
  end

  // Working registers: latch on start, advance through the chain while
  // busy, drop the remaining count on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= MSH_LSR;
      r_data  <= '0;
      r_carry <= 1'b0;
      r_vacc  <= 1'b0;
      r_rem   <= '0;
    end else if (cen) begin
      if (w_load) begin
        r_op    <= op;
        r_data  <= din;
        r_carry <= cin;
        r_vacc  <= 1'b0;
        r_rem   <= cnt;
      end else if (r_state == MSH_BUSY) begin
        if (abort) begin
          r_rem <= '0;
        end else begin
          r_data  <= w_sd[STEP];
          r_carry <= w_sc[STEP];
          r_vacc  <= r_vacc | w_vstep;
          r_rem   <= w_rem_nxt32[CW-1:0];
        end
      end
    end
  end

  // Result and flag registers: written only alongside a done pulse and
  // held otherwise, so an abort leaves the previous result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_dout <= '0;
      r_cc   <= '0;
    end else if (cen) begin
      r_done <= w_imm | w_fin;
      if (w_imm) begin
        r_dout <= din;
        r_cc   <= cc_pack(din[W-1], din == '0, 1'b0, cin);
      end else if (w_fin) begin
        r_dout <= w_sd[STEP];
        r_cc   <= cc_pack(w_sd[STEP][W-1], w_sd[STEP] == '0,
                          r_vacc | w_vstep, w_sc[STEP]);
      end
    end
  end

  assign busy  = (r_state == MSH_BUSY);
  assign done  = r_done;
  assign dout  = r_dout;
  assign c_out = r_cc[CC_C];
  assign v_out = r_cc[CC_V];
  assign n_out = r_cc[CC_N];
  assign z_out = r_cc[CC_Z];

endmodule

// File: tb/tb_jtkcpu_mshift.sv
// Scoreboard bench for jtkcpu_mshift: two instances (STEP=1 and STEP=4)
// share the same stimulus; each has its own expected-result queue and
// monitor that pops and compares whenever its done pulse appears.
module tb_jtkcpu_mshift;

  logic        clk;
  logic        rst_n;
  logic        cen;
  logic        start;
  logic        abort;
  logic [2:0]  op;
  logic [15:0] din;
  logic [4:0]  cnt;
  logic        cin;

  logic        busy1, done1, c1, v1, n1, z1;
  logic [15:0] dout1;
  logic        busy4, done4, c4, v4, n4, z4;
  logic [15:0] dout4;

  typedef struct {
    logic [15:0] dout;
    logic        c, v, n, z;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;
  int clk_cnt  = 0;
  int last_edge1 = -1;
  int last_edge4 = -1;
  int t0_edge, t0_clk;
  bit toggle = 1'b0;

  logic [15:0] last_dout;
  logic        last_c, last_v, last_n, last_z;

  jtkcpu_mshift #(.W(16), .CW(5), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .abort(abort),
    .op(op), .din(din), .cnt(cnt), .cin(cin),
    .busy(busy1), .done(done1), .dout(dout1),
    .c_out(c1), .v_out(v1), .n_out(n1), .z_out(z1)
  );

  jtkcpu_mshift #(.W(16), .CW(5), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .abort(abort),
    .op(op), .din(din), .cnt(cnt), .cin(cin),
    .busy(busy4), .done(done4), .dout(dout4),
    .c_out(c4), .v_out(v4), .n_out(n4), .z_out(z4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock-enable pattern: steady high, or alternating when toggle is set.
  initial cen = 1'b1;
  always @(posedge clk) begin
    #1;
    cen = toggle ? !cen : 1'b1;
  end

  always @(posedge clk) begin
    clk_cnt++;
    if (cen && rst_n) edge_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the STEP=1 instance.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && done1 && edge_cnt != last_edge1) begin
      last_edge1 = edge_cnt;
      check("s1 done_was_expected", q1.size() != 0, 1'b1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check($sformatf("%s s1 dout", e.name), dout1, e.dout);
        check($sformatf("%s s1 nzvc", e.name), {n1, z1, v1, c1},
              {e.n, e.z, e.v, e.c});
        check($sformatf("%s s1 latency", e.name), edge_cnt - e.t0, e.lat);
      end
    end
  end

  // Monitor for the STEP=4 instance.
  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && done4 && edge_cnt != last_edge4) begin
      last_edge4 = edge_cnt;
      check("s4 done_was_expected", q4.size() != 0, 1'b1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        check($sformatf("%s s4 dout", e.name), dout4, e.dout);
        check($sformatf("%s s4 nzvc", e.name), {n4, z4, v4, c4},
              {e.n, e.z, e.v, e.c});
        check($sformatf("%s s4 latency", e.name), edge_cnt - e.t0, e.lat);
      end
    end
  end

  // Present one request, wait for the accepting cen edge, queue the
  // hand-computed result. Entered and left at posedge+1.
  task automatic issue(input logic [2:0] i_op, input logic [15:0] i_din,
                       input logic [4:0] i_cnt, input logic i_cin,
                       input logic [15:0] e_dout, input logic e_n,
                       input logic e_z, input logic e_v, input logic e_c,
                       input bit do_push, input string name);
    exp_t e;
    bit   zero;
    op    = i_op;
    din   = i_din;
    cnt   = i_cnt;
    cin   = i_cin;
    start = 1'b1;
    do @(posedge clk); while (!cen);
    #1;
    start   = 1'b0;
    t0_edge = edge_cnt;
    t0_clk  = clk_cnt;
    zero    = (i_cnt == 5'd0) || (i_op > 3'd4);
    if (do_push) begin
      e.dout = e_dout; e.n = e_n; e.z = e_z; e.v = e_v; e.c = e_c;
      e.t0   = t0_edge;
      e.name = name;
      e.lat  = zero ? 0 : int'(i_cnt);
      q1.push_back(e);
      e.lat  = zero ? 0 : (int'(i_cnt) + 3) / 4;
      q4.push_back(e);
      last_dout = e_dout; last_n = e_n; last_z = e_z;
      last_v = e_v; last_c = e_c;
    end
    check($sformatf("%s s1 busy_after_t0", name), busy1, !zero);
    check($sformatf("%s s4 busy_after_t0", name), busy4, !zero);
  endtask

  // Wait until both scoreboards are drained, bounded.
  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (q1.size() == 0 && q4.size() == 0) break;
    end
    #1;
    check($sformatf("%s drained", name), q1.size() + q4.size(), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    op    = 3'd0;
    din   = 16'h0000;
    cnt   = 5'd0;
    cin   = 1'b0;
    last_dout = 16'h0; last_n = 0; last_z = 0; last_v = 0; last_c = 0;

    #3;
    check("reset s1 outputs", {busy1, done1, dout1, n1, z1, v1, c1}, 0);
    check("reset s4 outputs", {busy4, done4, dout4, n4, z4, v4, c4}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ASL 0x4001 by 2, with a second start ignored while busy.
    issue(3'd2, 16'h4001, 5'd2, 1'b0, 16'h0004, 0, 0, 1, 1, 1'b1, "asl2");
    start = 1'b1; op = 3'd0; din = 16'hFFFF; cnt = 5'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("asl2");

    issue(3'd1, 16'h8010, 5'd4,  1'b0, 16'hF801, 1, 0, 0, 0, 1'b1, "asr4");
    wait_idle("asr4");
    issue(3'd3, 16'h0001, 5'd17, 1'b1, 16'h0001, 0, 0, 0, 1, 1'b1, "ror17");
    wait_idle("ror17");
    issue(3'd4, 16'h8000, 5'd1,  1'b0, 16'h0000, 0, 1, 1, 1, 1'b1, "rol1");
    wait_idle("rol1");
    issue(3'd0, 16'hFFFF, 5'd20, 1'b0, 16'h0000, 0, 1, 0, 0, 1'b1, "lsr20");
    wait_idle("lsr20");
    issue(3'd3, 16'h0001, 5'd1,  1'b0, 16'h0000, 0, 1, 0, 1, 1'b1, "ror1");
    wait_idle("ror1");
    issue(3'd4, 16'h4000, 5'd1,  1'b1, 16'h8001, 1, 0, 1, 0, 1'b1, "rol1v");
    wait_idle("rol1v");
    issue(3'd1, 16'h7FFF, 5'd20, 1'b1, 16'h0000, 0, 1, 0, 0, 1'b1, "asr20");
    wait_idle("asr20");
    issue(3'd2, 16'h0003, 5'd3,  1'b1, 16'h0018, 0, 0, 0, 0, 1'b1, "asl3");
    wait_idle("asl3");
    issue(3'd0, 16'h8001, 5'd1,  1'b0, 16'h4000, 0, 0, 0, 1, 1'b1, "lsr1");
    wait_idle("lsr1");

    // Zero count and reserved op complete at T0 without busy; the second
    // start lands on the edge that clears the first done.
    issue(3'd0, 16'h1234, 5'd0, 1'b1, 16'h1234, 0, 0, 0, 1, 1'b1, "cnt0");
    issue(3'd6, 16'h1234, 5'd5, 1'b1, 16'h1234, 0, 0, 0, 1, 1'b1, "rsvd6");
    wait_idle("rsvd6");

    // Abort held while idle does not block a new request.
    abort = 1'b1;
    issue(3'd2, 16'h8000, 5'd0, 1'b0, 16'h8000, 1, 0, 0, 0, 1'b1, "idle_abort");
    abort = 1'b0;
    wait_idle("idle_abort");

    // Abort at the second step: no done, previous result held.
    issue(3'd2, 16'h4001, 5'd8, 1'b0, 16'h0, 0, 0, 0, 0, 1'b0, "abort");
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort s1 busy_done", {busy1, done1}, 2'b00);
    check("abort s4 busy_done", {busy4, done4}, 2'b00);
    check("abort s1 held", {dout1, n1, z1, v1, c1},
          {last_dout, last_n, last_z, last_v, last_c});
    check("abort s4 held", {dout4, n4, z4, v4, c4},
          {last_dout, last_n, last_z, last_v, last_c});
    repeat (30) @(posedge clk);
    #1;

    // Reset mid-operation clears everything asynchronously.
    issue(3'd3, 16'h0001, 5'd17, 1'b1, 16'h0, 0, 0, 0, 0, 1'b0, "reset");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midop reset s1", {busy1, done1, dout1, n1, z1, v1, c1}, 0);
    check("midop reset s4", {busy4, done4, dout4, n4, z4, v4, c4}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("post reset s1 idle", {busy1, done1}, 2'b00);

    // LSR 0xFFFF by 20 with cen every other clock: STEP=4 takes 10 clocks.
    toggle = 1'b1;
    issue(3'd0, 16'hFFFF, 5'd20, 1'b0, 16'h0000, 0, 1, 0, 0, 1'b1, "lsr20_cen");
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done4) break;
    end
    check("lsr20_cen s4 clocks", clk_cnt - t0_clk, 10);
    @(posedge clk);
    #1;
    wait_idle("lsr20_cen");
    toggle = 1'b0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/jtkcpu_mshift.md
# jtkcpu_mshift

Parametrised iterative multi-bit shifter/rotator for the KCPU datapath, successor to the ALU's fixed 16-bit multi-shift path. It takes an operand, an operation and a shift count, then performs `STEP` single-bit shifts per enabled cycle until the count is exhausted. It returns the result with 6809-style N/Z/V/C flags and a one-cycle `done` pulse. It sits beside the ALU and serves ASRD/LSRD/ASLD/RORD/ROLD (register and memory forms) and future wider variants.

## Interface
- `W`, 16: operand width, any value ≥ 2.
- `CW`, 5: count width.
- `STEP`, 1: bits shifted per `cen` cycle, 1..W.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cen`  in  1  clock enable; all state changes are qualified by it.
- `start`  in  1  request; sampled on a `cen` edge while idle.
- `abort`  in  1  cancel the operation in progress; higher priority than stepping.
- `op`  in  3  0 LSR, 1 ASR, 2 ASL, 3 ROR, 4 ROL; 5–7 reserved.
- `din`  in  W  operand.
- `cnt`  in  CW  shift count.
- `cin`  in  1  carry in (CC_C).
- `busy`  out  1  operation in progress.
- `done`  out  1  result valid, one `cen` period.
- `dout`  out  W  result.
- `c_out`, `v_out`, `n_out`, `z_out`  out  1 each  flags.

## Operation
- Idle, `cen`=1, `start`=1: latch `op`, `din`, `cin` and remaining count `rem=cnt`; clear the V accumulator.
- A reserved op is treated as count 0.
- Each active cycle applies `min(STEP, rem)` single-bit steps, then `rem -= steps`.
- Step rules:
  - LSR: 0 enters the MSB.
  - ASR: the MSB is replicated.
  - ASL: 0 enters the LSB.
  - ROR/ROL: rotate through carry, i.e. a (W+1)-bit ring.
  - C takes the bit shifted out on every step.
- V is the OR over all steps of (MSB before ^ MSB after), for ASL and ROL only. It is 0 for the other ops.
- Count may exceed W.
  - LSR/ASL saturate to 0 (or all-sign for ASR).
  - Rotations wrap modulo W+1.
  - Every bit is still iterated; there is no shortcut.
- Final flags: `n_out=dout[W-1]`, `z_out=(dout==0)`. `c_out` is the last bit out, or `cin` when count is 0.
- Flags and `dout` update only when `done` rises, and hold otherwise.
- `start` while busy is ignored.
- `abort` with `cen`: `busy` drops and `done` stays low; `dout`/flags keep their previous values.
- `abort` while idle has no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `dout`=0, all flags 0, `rem`=0.
- `start` is accepted at `cen` edge T0.
  - Count k>0: `busy`=1 from T0; shifting happens at edges T1..Tn, n=ceil(k/STEP).
  - At Tn: `busy`=0, `done`=1, and `dout`/flags are valid.
  - Count 0: `busy` stays 0; `done`=1 after T0 with `dout=din`, C=`cin`, V=0.
- `done` clears at the next `cen` edge. A new `start` may coincide with that edge and is accepted.
- `cen`=0 freezes all state, including `done`.
- Reset asserted mid-operation forces the reset values immediately; the operation is lost.

## Structure
- Shared `jtkcpu_pkg` holds the op encodings (`MSH_LSR` … `MSH_ROL`) and the flag bit indices (`CC_C`, `CC_V`, `CC_Z`, `CC_N`), which are common with the ALU.
- One sub-module, `jtkcpu_mshift_step`: combinational single-bit step with inputs (op, data, carry), outputs (data, carry, vflag). It is instantiated `STEP` times in a chain; per-stage enables come from `rem`.
- Top level holds the idle/busy control, the `rem` counter, the V accumulator and the output registers.

## Test plan
- W=16, STEP=1, ASL, din=0x4001, cnt=2 -> after 2 `cen` cycles `dout`=0x0004, C=1, V=1, N=0, Z=0; `done` high for one `cen` cycle.
- ASR, din=0x8010, cnt=4, STEP=4 -> `done` after 1 cycle; `dout`=0xF801, C=0, N=1, V=0.
- ROR, din=0x0001, cin=1, cnt=17 -> `dout`=0x0001, C=1 (full W+1 wrap).
  - ROL, din=0x8000, cin=0, cnt=1 -> `dout`=0x0000, C=1, Z=1, V=1.
- LSR, din=0xFFFF, cnt=20, STEP=4 -> 5 active cycles, `dout`=0, C=0, Z=1.
  - With `cen` toggling every other clock: 10 clocks, same result.
- Count 0 and reserved op=6, din=0x1234, cin=1 -> `done` after T0 with no `busy`; `dout`=0x1234, C=1.
- Protocol checks:
  - `start` during busy is ignored.
  - `abort` at the second step -> `busy`=0, no `done`, outputs unchanged.
  - `rst_n` low mid-operation -> all outputs 0 asynchronously.
